// File: rtl/cpu_phase_sequencer.sv
// Phase register and instruction register for a multi-cycle CPU: sequences IF/ID/EXEC/MEM/WB,
// resolves branches and counts retirements. Define SEQ_HALT_ON_ILLEGAL_EN to halt on unsupported instructions.
module cpu_phase_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      mem_rdata,
    input  logic             zero,
    output logic [2:0]       state,
    output logic [31:0]      instruction,
    output logic             branch_taken,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXEC = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } phase_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    phase_e           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             bt_q, bt_d;
    logic             ill_q, ill_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_rtype;
    logic       is_r_alu;
    logic       is_jr;
    logic       is_j;
    logic       is_jal;
    logic       is_beq;
    logic       is_bne;
    logic       is_lw;
    logic       is_sw;
    logic       is_imm;
    logic       needs_mem;
    logic       is_legal;
    logic       enter_if;

    // Instruction class decode, always taken from the latched IR.
    always_comb begin
        opcode    = instr_q[31:26];
        funct     = instr_q[5:0];
        is_rtype  = (opcode == OP_RTYPE);
        is_r_alu  = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
        is_jr     = is_rtype && (funct == FN_JR);
        is_j      = (opcode == OP_J);
        is_jal    = (opcode == OP_JAL);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_lw     = (opcode == OP_LW);
        is_sw     = (opcode == OP_SW);
        is_imm    = (opcode == OP_ADDI) || (opcode == OP_XORI);
        needs_mem = is_lw || is_sw || is_beq || is_bne;
        is_legal  = is_r_alu || is_jr || is_j || is_jal || needs_mem || is_imm;
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        bt_d     = bt_q;
        ill_d    = ill_q;
        retire_d = 1'b0;
        count_d  = count_q;
        enter_if = 1'b0;

        case (state_q)
            S_IF: begin
                if (!stall) begin
                    instr_d = mem_rdata;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_j) begin
                    enter_if = 1'b1;
                end else if (!is_legal) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
                    state_d = S_HALT;
                    ill_d   = 1'b1;
`else
                    enter_if = 1'b1;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (needs_mem) begin
                    state_d = S_MEM;
                end else if (is_jr) begin
                    enter_if = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Branch outcome is committed only on the edge that leaves MEM.
                if (!stall) begin
                    if (is_beq) begin
                        bt_d = zero;
                    end else if (is_bne) begin
                        bt_d = ~zero;
                    end
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        enter_if = 1'b1;
                    end
                end
            end
            S_WB: begin
                enter_if = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unreachable encodings recover to IF without counting a retirement.
                state_d = S_IF;
            end
        endcase

        if (enter_if) begin
            state_d  = S_IF;
            retire_d = 1'b1;
            count_d  = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IF;
            instr_q  <= 32'd0;
            bt_q     <= 1'b0;
            ill_q    <= 1'b0;
            retire_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            bt_q     <= bt_d;
            ill_q    <= ill_d;
            retire_q <= retire_d;
            count_q  <= count_d;
        end
    end

    assign state         = state_q;
    assign instruction   = instr_q;
    assign branch_taken  = bt_q;
    assign illegal       = ill_q;
    assign retire        = retire_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: per-instruction phase-path model feeding an expected queue.
module tb_cpu_phase_sequencer;

  localparam int CNT_W = 4;
  localparam logic [2:0] P_IF   = 3'd0;
  localparam logic [2:0] P_ID   = 3'd1;
  localparam logic [2:0] P_EXEC = 3'd2;
  localparam logic [2:0] P_MEM  = 3'd3;
  localparam logic [2:0] P_WB   = 3'd4;
  localparam logic [2:0] P_HALT = 3'd5;

  typedef struct packed {
    logic [2:0]       st;
    logic             ret;
    logic [CNT_W-1:0] cnt;
    logic             bt;
    logic             ill;
    logic [31:0]      ir;
  } rec_t;
  localparam int EW = $bits(rec_t);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic [31:0]      mem_rdata = 32'd0;
  logic             zero = 1'b0;
  logic [2:0]       state;
  logic [31:0]      instruction;
  logic             branch_taken;
  logic             illegal;
  logic             retire;
  logic [CNT_W-1:0] retired_count;

  cpu_phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .mem_rdata(mem_rdata), .zero(zero),
    .state(state), .instruction(instruction), .branch_taken(branch_taken),
    .illegal(illegal), .retire(retire), .retired_count(retired_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // model state carried between instructions
  logic [CNT_W-1:0] m_count = '0;
  logic [31:0]      m_ir = 32'd0;
  logic             m_bt = 1'b0;
  logic             m_ret = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 J, 1 JR, 2 EXEC+WB, 3 EXEC+MEM, 4 LW, 5 unsupported
  function automatic int icls(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    case (op)
      6'h23: return 4;
      6'h2B, 6'h04, 6'h05: return 3;
      6'h02: return 0;
      6'h03, 6'h0E, 6'h08: return 2;
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return 2;
        if (fn == 6'h08) return 1;
        return 5;
      end
      default: return 5;
    endcase
  endfunction

  function automatic void model_reset();
    m_count = '0;
    m_ir = 32'd0;
    m_bt = 1'b0;
    m_ret = 1'b0;
  endfunction

  // Runs one instruction from its first IF cycle; stop_after>0 truncates it (model not advanced).
  task automatic run_instr(input logic [31:0] word, input int if_st, input int mem_st,
                           input logic z, input int stop_after);
    logic [2:0] path[$];
    int c;
    int n;
    int mcnt;
    logic halted;
    rec_t r;
    c = icls(word);
    halted = 1'b0;
    for (int i = 0; i <= if_st; i++) path.push_back(P_IF);
    path.push_back(P_ID);
    case (c)
      1: path.push_back(P_EXEC);
      2: begin path.push_back(P_EXEC); path.push_back(P_WB); end
      3, 4: begin
        path.push_back(P_EXEC);
        for (int i = 0; i <= mem_st; i++) path.push_back(P_MEM);
        if (c == 4) path.push_back(P_WB);
      end
      5: begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
        halted = 1'b1;
        for (int i = 0; i < 4; i++) path.push_back(P_HALT);
`endif
      end
      default: ;
    endcase
    n = (stop_after > 0) ? stop_after : path.size();
    for (int i = 0; i < n; i++) begin
      r.st  = path[i];
      r.ret = (i == 0) ? m_ret : 1'b0;
      r.cnt = m_count;
      r.bt  = m_bt;
      r.ill = (path[i] == P_HALT);
      r.ir  = (path[i] == P_IF) ? m_ir : word;
      exp_q.push_back(r);
    end
    // driver
    mcnt = 0;
    for (int i = 0; i < n; i++) begin
      zero = z;
      if (path[i] == P_IF) begin
        stall = (i < if_st);
        mem_rdata = (i == if_st) ? word : $urandom;
      end else if (path[i] == P_MEM) begin
        stall = (mcnt < mem_st);
        mcnt++;
        mem_rdata = $urandom;
      end else begin
        stall = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    if (stop_after == 0) begin
      m_ir = word;
      if (word[31:26] == 6'h04) m_bt = z;
      if (word[31:26] == 6'h05) m_bt = ~z;
      if (!halted) m_count = m_count + 1'b1;
      m_ret = ~halted;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    stall = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_branch_taken", 32'(branch_taken), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_retired_count", 32'(retired_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // scoreboard compare, one record per clock while not in reset
  rec_t cmp_r;
  always @(negedge clk) begin
    if (!reset && exp_q.size() > 0) begin
      cmp_r = exp_q.pop_front();
      chk("state", 32'(state), 32'(cmp_r.st));
      chk("retire", 32'(retire), 32'(cmp_r.ret));
      chk("retired_count", 32'(retired_count), 32'(cmp_r.cnt));
      chk("branch_taken", 32'(branch_taken), 32'(cmp_r.bt));
      chk("illegal", 32'(illegal), 32'(cmp_r.ill));
      chk("instruction", instruction, cmp_r.ir);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    run_instr(32'h8C220004, 0, 0, 1'b0, 0);               // LW
    chk("lw_state", 32'(state), 32'd0);
    chk("lw_retire", 32'(retire), 32'd1);
    chk("lw_count", 32'(retired_count), 32'd1);

    run_instr(32'h10220003, 0, 0, 1'b1, 0);               // BEQ taken
    chk("beq_taken", 32'(branch_taken), 32'd1);
    run_instr(32'h14220003, 0, 0, 1'b1, 0);               // BNE not taken
    chk("bne_not_taken", 32'(branch_taken), 32'd0);

    run_instr(32'h08000010, 0, 0, 1'b0, 0);               // J
    run_instr(32'h03E00008, 0, 0, 1'b0, 0);               // JR
    chk("j_jr_count", 32'(retired_count), 32'd5);

    run_instr(32'h00221820, 3, 0, 1'b0, 0);               // ADD, IF stalled
    chk("if_stall_ir", instruction, 32'h00221820);
    run_instr(32'hAC220004, 0, 3, 1'b1, 0);               // SW, MEM stalled
    run_instr(32'h14220003, 0, 2, 1'b0, 0);               // BNE taken after stall
    chk("bne_taken", 32'(branch_taken), 32'd1);
    run_instr(32'h00221822, 1, 0, 1'b0, 0);               // SUB
    run_instr(32'h0022182A, 0, 0, 1'b1, 0);               // SLT
    run_instr(32'h0C000010, 0, 0, 1'b0, 0);               // JAL
    run_instr(32'h38420001, 0, 0, 1'b0, 0);               // XORI
    run_instr(32'h20420001, 0, 0, 1'b1, 0);               // ADDI
    run_instr(32'h8C220004, 2, 1, 1'b0, 0);               // LW
    run_instr(32'hAC220004, 0, 0, 1'b0, 0);               // SW
    run_instr(32'h00221820, 0, 0, 1'b0, 0);               // ADD: 16th retirement wraps
    chk("count_wrap", 32'(retired_count), 32'd0);
    chk("bt_held", 32'(branch_taken), 32'd1);

`ifdef SEQ_HALT_ON_ILLEGAL_EN
    run_instr(32'hFC000000, 0, 0, 1'b0, 0);
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_illegal", 32'(illegal), 32'd1);
    chk("halt_no_retire", 32'(retire), 32'd0);
    do_reset();
    run_instr(32'h00000001, 0, 0, 1'b0, 0);
    chk("halt2_illegal", 32'(illegal), 32'd1);
    do_reset();
`else
    run_instr(32'hFC000000, 0, 0, 1'b0, 0);
    chk("nop_illegal", 32'(illegal), 32'd0);
    chk("nop_retire", 32'(retire), 32'd1);
    chk("nop_count", 32'(retired_count), 32'd1);
    run_instr(32'h00000001, 0, 0, 1'b0, 0);
    chk("nop2_count", 32'(retired_count), 32'd2);
`endif

    run_instr(32'h08000010, 0, 0, 1'b0, 0);               // J, so count is nonzero
    run_instr(32'h20420001, 0, 0, 1'b0, 2);               // ADDI, stop in EXEC
    chk("mid_exec_state", 32'(state), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_count", 32'(retired_count), 32'd0);
    chk("async_instruction", instruction, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run_instr(32'h8C220004, 0, 0, 1'b0, 0);
    chk("post_reset_count", 32'(retired_count), 32'd1);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
